// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FQ_PC_W  = 9;
  localparam int FQ_INS_W = 32;
  localparam int PC_STEP  = 4;

  // Value presented to decode when nothing is valid; matches the pipeline flush value.
  localparam logic [FQ_INS_W-1:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [FQ_PC_W-1:0]  pc;
    logic [FQ_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and imem.
interface fetch_queue_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [INS_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with combinational head read, clear, and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited imem requests,
// in-order response tagging, and a prefetch FIFO feeding the IF/ID register.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_W      = FQ_PC_W,
  parameter int INS_W     = FQ_INS_W,
  parameter int DEPTH     = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              id_ready,
  fetch_queue_if.master     imem,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [INS_W-1:0]  if_instr,
  output logic [PC_W-1:0]   fetch_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   ent_count;
  logic            ent_full, ent_empty, ent_push, ent_pop, ent_clear;
  fetch_entry_t    push_entry, head_entry;

  // The tag queue occupancy is the outstanding-request count.
  logic [OW-1:0]   tag_count;
  logic            tag_full, tag_empty;
  logic [PC_W-1:0] tag_head;

  logic            room, fire, beat;

  always_comb begin
    beat          = imem.imem_rvalid && !tag_empty;
    room          = ((int'(ent_count) + int'(tag_count)) < DEPTH) && !tag_full;
    imem.imem_req  = !reset && !redirect && room;
    imem.imem_addr = fetch_pc_q;
    fire          = imem.imem_req && imem.imem_gnt;

    push_entry.pc    = tag_head;
    push_entry.instr = imem.imem_rdata;

    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    ent_push   = 1'b0;
    ent_pop    = 1'b0;
    ent_clear  = 1'b0;

    if (redirect) begin
      // Everything still in flight (minus a beat landing now) is stale.
      ent_clear  = 1'b1;
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      drop_d     = tag_count - OW'(beat);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
      if (beat) begin
        if (drop_q != '0) drop_d   = drop_q - OW'(1);
        else              ent_push = 1'b1;
      end
      ent_pop = !ent_empty && id_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (ent_clear),
    .push  (ent_push),
    .pop   (ent_pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (ent_count),
    .full  (ent_full),
    .empty (ent_empty)
  );

  // Never cleared on redirect: it drains in step with the dropped beats.
  sync_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .push  (fire),
    .pop   (beat),
    .wdata (fetch_pc_q),
    .rdata (tag_head),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  assign if_valid = !ent_empty;
  assign if_pc    = if_valid ? head_entry.pc : '0;
  assign if_instr = if_valid ? head_entry.instr : BUBBLE_INSTR;
  assign fetch_pc = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(imem.imem_rvalid && tag_empty))
        else $error("imem_rvalid with no request outstanding");
      assert (!(ent_push && ent_full && !ent_pop))
        else $error("entry fifo overflow");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a 1..3-cycle-latency in-order imem model.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, redirect, id_ready;
  logic [8:0]  redirect_pc;
  logic        if_valid;
  logic [8:0]  if_pc, fetch_pc;
  logic [31:0] if_instr;

  logic [1:0]  lat;
  logic [2:0]  sv;
  logic [8:0]  sa [3];
  logic        rv;
  logic [8:0]  ra;

  logic [8:0]  exp_pc;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          vcnt  = 0;
  int          n;

  always #5 clk = ~clk;

  fetch_queue_if #(.PC_W(9), .INS_W(32)) imem_bus ();

  fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_ready    (id_ready),
    .imem        (imem_bus),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .fetch_pc    (fetch_pc)
  );

  // In-order memory: a grant reappears as a response lat cycles later.
  always @(posedge clk) begin
    if (reset) begin
      sv <= '0;
    end else begin
      sv    <= {sv[1:0], imem_bus.imem_req && imem_bus.imem_gnt};
      sa[0] <= imem_bus.imem_addr;
      sa[1] <= sa[0];
      sa[2] <= sa[1];
    end
  end

  always_comb begin
    rv = sv[2];
    ra = sa[2];
    case (lat)
      2'd1:    begin rv = sv[0]; ra = sa[0]; end
      2'd2:    begin rv = sv[1]; ra = sa[1]; end
      default: begin rv = sv[2]; ra = sa[2]; end
    endcase
  end

  assign imem_bus.imem_rvalid = rv;
  assign imem_bus.imem_rdata  = 32'hA000_0000 | {23'b0, ra};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks the presented instruction against the expected in-order stream, then advances a cycle.
  task automatic tick();
    #1;
    if (reset) begin
      exp_pc = 9'h000;
    end else if (redirect) begin
      exp_pc = redirect_pc & 9'h1FC;
    end else if (if_valid) begin
      chk("stream_pc", 32'(if_pc), 32'(exp_pc));
      chk("stream_instr", if_instr, 32'hA000_0000 | 32'(exp_pc));
      if (id_ready) begin
        $display("pop pc=0x%03h instr=0x%08h", if_pc, if_instr);
        exp_pc = exp_pc + 9'd4;
        vcnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, input string tag, output int cnt);
    cnt = 0;
    while (!if_valid && cnt < max) begin
      tick();
      cnt++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    imem_bus.imem_gnt = 1'b1; lat = 2'd1; exp_pc = '0;
    tick(); tick();

    // Reset state
    chk("rst_req", 32'(imem_bus.imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_fetch_pc", 32'(fetch_pc), 32'd0);

    // Sequential fetch, 1-cycle memory
    reset = 1'b0;
    #1;
    chk("t1_req_c0", 32'(imem_bus.imem_req), 32'd1);
    chk("t1_addr_c0", 32'(imem_bus.imem_addr), 32'h000);
    tick();
    chk("t1_valid_c1", 32'(if_valid), 32'd0);
    chk("t1_fetch_pc_c1", 32'(fetch_pc), 32'h004);
    tick();
    chk("t1_valid_c2", 32'(if_valid), 32'd1);
    chk("t1_pc_c2", 32'(if_pc), 32'h000);
    chk("t1_instr_c2", if_instr, 32'hA000_0000);
    for (int i = 0; i < 4; i++) tick();
    chk("t1_pc_c6", 32'(if_pc), 32'h010);
    chk("t1_fetch_pc_c6", 32'(fetch_pc), 32'h018);

    // Decode stall fills the FIFO and throttles requests
    id_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2_req_stalled", 32'(imem_bus.imem_req), 32'd0);
    chk("t2_fetch_pc", 32'(fetch_pc), 32'h020);
    chk("t2_pc_held", 32'(if_pc), 32'h010);
    id_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_no_gaps", 32'(vcnt), 32'd8);
    chk("t2_pc_after", 32'(if_pc), 32'h030);

    // Redirect in the same cycle as a response beat
    redirect = 1'b1; redirect_pc = 9'h080;
    #1;
    chk("t4_req_redirect", 32'(imem_bus.imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    chk("t4_empty_next", 32'(if_valid), 32'd0);
    chk("t4_bubble_instr", if_instr, 32'd0);
    chk("t4_fetch_pc", 32'(fetch_pc), 32'h080);
    wait_valid(10, "t4_wait", n);
    chk("t4_latency", 32'(n), 32'd2);
    chk("t4_first_pc", 32'(if_pc), 32'h080);

    // PC wrap, with unaligned redirect target
    redirect = 1'b1; redirect_pc = 9'h1FF;
    tick();
    redirect = 1'b0;
    wait_valid(10, "t5_wait", n);
    chk("t5_pc0", 32'(if_pc), 32'h1FC);
    chk("t5_instr0", if_instr, 32'hA000_01FC);
    tick();
    chk("t5_pc1", 32'(if_pc), 32'h000);
    tick();
    chk("t5_pc2", 32'(if_pc), 32'h004);

    // Grant withheld: request and address hold steady
    redirect = 1'b1; redirect_pc = 9'h100;
    tick();
    redirect = 1'b0;
    imem_bus.imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t6_req_hold", 32'(imem_bus.imem_req), 32'd1);
      chk("t6_addr_hold", 32'(imem_bus.imem_addr), 32'h100);
      chk("t6_fetch_pc_hold", 32'(fetch_pc), 32'h100);
      tick();
    end
    imem_bus.imem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_streaming", 32'(if_valid), 32'd1);

    // Reset mid-stream
    reset = 1'b1;
    #1;
    chk("t6_rst_req_now", 32'(imem_bus.imem_req), 32'd0);
    tick();
    chk("t6_rst_valid", 32'(if_valid), 32'd0);
    chk("t6_rst_pc", 32'(if_pc), 32'd0);
    chk("t6_rst_instr", if_instr, 32'd0);
    chk("t6_rst_fetch_pc", 32'(fetch_pc), 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_restart_addr", 32'(imem_bus.imem_addr), 32'h000);
    chk("t6_restart_req", 32'(imem_bus.imem_req), 32'd1);
    wait_valid(10, "t6_restart_wait", n);
    chk("t6_restart_latency", 32'(n), 32'd2);
    chk("t6_restart_pc", 32'(if_pc), 32'h000);

    // Two requests in flight (0x010, 0x014) when a redirect hits; 3-cycle memory
    reset = 1'b1; lat = 2'd3;
    tick(); tick();
    reset = 1'b0; redirect = 1'b1; redirect_pc = 9'h010;
    tick();
    redirect = 1'b0;
    tick(); tick();
    chk("t3_req_credit_limit", 32'(imem_bus.imem_req), 32'd0);
    chk("t3_fetch_pc_pre", 32'(fetch_pc), 32'h018);
    redirect = 1'b1; redirect_pc = 9'h040;
    tick();
    redirect = 1'b0;
    chk("t3_fetch_pc", 32'(fetch_pc), 32'h040);
    chk("t3_req_still_full", 32'(imem_bus.imem_req), 32'd0);
    wait_valid(20, "t3_wait", n);
    chk("t3_latency", 32'(n), 32'd5);
    chk("t3_first_pc", 32'(if_pc), 32'h040);
    for (int i = 0; i < 12; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the IF/ID pipeline register.
- Generates sequential PCs and issues requests to a variable-latency instruction memory.
- Buffers returned instructions with their PCs in a small prefetch FIFO and presents one {pc, instr} per cycle to decode.
- Honours decode stalls (load-use hazard) and branch redirects/flushes from the execute-stage branch unit.

Parameters:
PC_W, 9, program-counter / instruction-address width (byte address)
INS_W, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTST, 2, maximum memory requests in flight (power of 2, <=DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect  in  1  branch taken / flush request from execute
redirect_pc  in  PC_W  target PC when redirect=1
id_ready  in  1  decode accepts an instruction this cycle (low = stall)
imem_req  out  1  memory request valid
imem_addr  out  PC_W  memory request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid; responses return in order
imem_rdata  in  INS_W  response instruction
if_valid  out  1  if_pc/if_instr hold a valid instruction
if_pc  out  PC_W  PC of presented instruction
if_instr  out  INS_W  presented instruction; 0 when if_valid=0
fetch_pc  out  PC_W  next PC to be requested (debug)

Behaviour:
- Reset is synchronous and active-high on clk and overrides all other inputs. On reset: fetch_pc=0, FIFO empty, outstanding=0, drop=0, tag queue empty, imem_req=0, if_valid=0, if_pc=0, if_instr=0.
- Issue: imem_req = !reset && !redirect && (fifo_count+outstanding < DEPTH) && (outstanding < MAX_OUTST). imem_addr = fetch_pc.
- On req&&gnt: outstanding+1, push fetch_pc into the tag queue, fetch_pc += 4 modulo 2^PC_W (0x1FC wraps to 0x000).
- With req=1 and gnt=0, imem_req and imem_addr hold stable; state does not advance.
- Response: on rvalid, outstanding-1 and the tag queue pops.
  - If drop>0: decrement drop and discard the beat.
  - Otherwise: push {tag, rdata} into the FIFO.
  - Credit accounting guarantees the FIFO never overflows.
- rvalid with outstanding=0 is a protocol error: ignore the beat and fire a simulation assertion.
- Output:
  - if_valid = FIFO non-empty.
  - Pop when if_valid && id_ready && !redirect.
  - No bypass: minimum latency is gnt at cycle N, rvalid at N+1, if_valid at N+2.
  - Throughput is 1 instruction/cycle once primed.
- Redirect (takes priority over pop, push and issue in the same cycle):
  - FIFO cleared.
  - fetch_pc <= redirect_pc.
  - drop <= outstanding − rvalid, with any rvalid beat in that cycle discarded.
  - imem_req=0 that cycle.
  - Tag queue is not cleared; it drains with the dropped responses.
  - Issue resumes the next cycle.
- Redirect while drop>0: drop accumulates to the new in-flight total. No stale instruction may ever reach the output after a redirect.
- Simultaneous push and pop on a non-empty FIFO: count unchanged. Push into an empty FIFO becomes visible the next cycle.
- Reset mid-operation: all state is cleared as above. The instruction memory shares the same reset, so no responses follow.
- All PCs are byte addresses, 4-aligned. The low 2 bits of redirect_pc are forced to 0.

Decomposition:
- Package fetch_pkg:
  - fetch_entry_t struct {pc [PC_W-1:0], instr [INS_W-1:0]}
  - PC_STEP = 4
  - BUBBLE_INSTR = 32'h0000_0000, matching the pipeline flush value
- One sub-module, sync_fifo (parameterised width/depth, push/pop/clear, count, full/empty). Instantiated twice: the entry FIFO (DEPTH) and the tag queue (MAX_OUTST, width PC_W).

Test Plan:
1. Reset released, id_ready=1, memory gnt=1 with 1-cycle latency returning rdata=0xA000_0000|addr -> if_pc 0x000,0x004,0x008,… on consecutive cycles starting 2 cycles after the first grant, if_instr matching each address.
2. id_ready=0 for 10 cycles -> FIFO fills to 4 entries, imem_req deasserts, if_pc held. Release -> PCs continue in order with no gaps or duplicates.
3. Two requests outstanding (PCs 0x010, 0x014), redirect with redirect_pc=0x040 -> both stale responses discarded, next if_valid shows if_pc=0x040.
4. Redirect coinciding with rvalid and id_ready=1 -> no pop, the beat is dropped, the FIFO is empty next cycle, and the first output is the redirect target.
5. redirect_pc=0x1FC -> if_pc sequence 0x1FC, 0x000, 0x004.
6. gnt held low 5 cycles with req=1 -> imem_addr stable, fetch_pc unchanged. Assert reset mid-stream -> every output reaches its reset value the next cycle, then fetch restarts at 0x000.
